seq_divider: RTL and testbench

//  Multi-cycle signed/unsigned integer divider with a start/done handshake.
//  It is the inverse companion of the team's sequential Booth multiplier.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_datapath.sv | 142 ++++++++++++++
 rtl/seq_divider.sv | 95 +++++++++
 tb/tb_seq_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Shift/subtract datapath for seq_divider: operand latches, magnitude conversion,
// one restoring step per iter cycle and the final sign correction.
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic             iter_i,
    input  logic             fix_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             cnt_last_o,
    output logic             vz_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dz_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sm_q, sm_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    // P' is one bit wider than P; after the conditional subtract it always
    // fits back into WIDTH bits because the result is below |divisor|.
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] p_sub;
    logic             ge;
    logic             d_neg, v_neg;
    logic [WIDTH-1:0] d_mag, v_mag;

    always_comb begin
        p_shift = {p_q, d_q[WIDTH-1]};
        ge      = (p_shift >= {1'b0, v_q});
        p_sub   = p_shift[WIDTH-1:0] - v_q;
        d_neg   = sm_q & d_q[WIDTH-1];
        v_neg   = sm_q & v_q[WIDTH-1];
        d_mag   = d_neg ? (~d_q + 1'b1) : d_q;
        v_mag   = v_neg ? (~v_q + 1'b1) : v_q;
    end

    always_comb begin
        d_d        = d_q;
        v_d        = v_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        sm_d       = sm_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        if (ld_i) begin
            d_d  = dividend_i;
            v_d  = divisor_i;
            sm_d = signed_mode_i;
        end else if (clr_i) begin
            ovf_d = 1'b0;
            if (vz_o) begin
                quot_d = '1;
                rem_d  = d_q;
                dz_d   = 1'b1;
            end else begin
                dz_d       = 1'b0;
                d_d        = d_mag;
                v_d        = v_mag;
                sign_q_d   = d_neg ^ v_neg;
                sign_r_d   = d_neg;
                ovf_pend_d = sm_q && (d_q == MIN_NEG) && (v_q == '1);
                p_d        = '0;
                cnt_d      = CW'(WIDTH);
            end
        end else if (iter_i) begin
            p_d   = ge ? p_sub : p_shift[WIDTH-1:0];
            d_d   = {d_q[WIDTH-2:0], ge};
            cnt_d = cnt_q - 1'b1;
        end else if (fix_i) begin
            // -2^(W-1)/-1 wraps naturally to MIN_NEG with a zero remainder.
            quot_d = sign_q_q ? (~d_q + 1'b1) : d_q;
            rem_d  = sign_r_q ? (~p_q + 1'b1) : p_q;
            ovf_d  = ovf_pend_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q        <= '0;
            v_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            sm_q       <= 1'b0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            d_q        <= d_d;
            v_q        <= v_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            sm_q       <= sm_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cnt_last_o = (cnt_q == CW'(1));
    assign vz_o       = (v_q == '0);
    assign quot_o     = quot_q;
    assign rem_o      = rem_q;
    assign dz_o       = dz_q;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider: controller FSM around div_datapath,
// one quotient bit per ITER cycle, start/done handshake.
//
//  state  | meaning
//  IDLE   | after reset, waiting for the first start
//  LOAD   | divide-by-zero check, magnitudes and signs captured
//  ITER   | one restoring shift/subtract step per cycle, WIDTH cycles
//  FIX    | sign correction of quotient/remainder, overflow flag
//  DONE   | result valid and held; start launches the next division
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    div_state_e state_q, state_d;
    logic       ld, clr, iter, fix;
    logic       cnt_last, vz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        clr     = 1'b0;
        iter    = 1'b0;
        fix     = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    ld      = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                clr     = 1'b1;
                state_d = vz ? S_DONE : S_ITER;
            end
            S_ITER: begin
                iter = 1'b1;
                if (cnt_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                fix     = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_i          (ld),
        .clr_i         (clr),
        .iter_i        (iter),
        .fix_i         (fix),
        .signed_mode_i (signed_mode),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .cnt_last_o    (cnt_last),
        .vz_o          (vz),
        .quot_o        (quotient),
        .rem_o         (remainder),
        .dz_o          (div_by_zero),
        .ovf_o         (overflow)
    );

endmodule

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider (WIDTH=8) against hand values and a / % model.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one division; edges counts rising edges from the sampling edge (=1) to done.
    task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                          output int edges, output logic busy_ok);
        @(negedge clk);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        edges    = 1;
        busy_ok  = 1'b1;
        while (!done && edges < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    function automatic void model(input logic sm, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 8'd0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q  = 8'h80;
                r  = 8'h00;
                ov = 1'b1;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        int         edges;
        logic       bok;
        int         saw_done;
        logic [7:0] eq, er;
        logic       edz, eov;
        logic       sm;
        logic [7:0] a, b;

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = 8'd0;
        divisor     = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 100/7 unsigned, latency and busy window
        run_op(1'b0, 8'd100, 8'd7, edges, bok);
        check("u100_7_q", 32'(quotient), 32'd14);
        check("u100_7_r", 32'(remainder), 32'd2);
        check("u100_7_lat", 32'(edges), 32'd11);
        check("u100_7_busy", 32'(bok), 32'd1);
        check("u100_7_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_q", 32'(quotient), 32'd14);
        check("hold_done", 32'(done), 32'd1);

        // signed sign handling
        run_op(1'b1, 8'h9C, 8'd7, edges, bok);
        check("s-100_7_q", 32'(quotient), 32'hF2);
        check("s-100_7_r", 32'(remainder), 32'hFE);
        run_op(1'b1, 8'd100, 8'hF9, edges, bok);
        check("s100_-7_q", 32'(quotient), 32'hF2);
        check("s100_-7_r", 32'(remainder), 32'h02);

        // divide by zero, then a normal op must clear the flag
        run_op(1'b0, 8'd5, 8'd0, edges, bok);
        check("dz_flag", 32'(div_by_zero), 32'd1);
        check("dz_q", 32'(quotient), 32'hFF);
        check("dz_r", 32'(remainder), 32'h05);
        check("dz_lat", 32'(edges), 32'd2);
        run_op(1'b0, 8'd9, 8'd3, edges, bok);
        check("dz_clr_flag", 32'(div_by_zero), 32'd0);
        check("b2b_q", 32'(quotient), 32'd3);
        check("b2b_r", 32'(remainder), 32'd0);

        // overflow corner vs the same bits unsigned
        run_op(1'b1, 8'h80, 8'hFF, edges, bok);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_q", 32'(quotient), 32'h80);
        check("ovf_r", 32'(remainder), 32'h00);
        run_op(1'b0, 8'h80, 8'hFF, edges, bok);
        check("u80_ff_ovf", 32'(overflow), 32'd0);
        check("u80_ff_q", 32'(quotient), 32'h00);
        check("u80_ff_r", 32'(remainder), 32'h80);

        // start pulsed mid-ITER must be ignored
        @(negedge clk);
        signed_mode = 1'b0;
        dividend    = 8'd100;
        divisor     = 8'd7;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 1;
        repeat (4) @(posedge clk);
        #1;
        edges += 4;
        signed_mode = 1'b1;
        dividend    = 8'd50;
        divisor     = 8'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges++;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("ign_lat", 32'(edges), 32'd11);
        check("ign_q", 32'(quotient), 32'd14);
        check("ign_r", 32'(remainder), 32'd2);

        // async reset mid-ITER
        @(negedge clk);
        signed_mode = 1'b0;
        dividend    = 8'd200;
        divisor     = 8'd9;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_q", 32'(quotient), 32'd0);
        check("arst_r", 32'(remainder), 32'd0);
        check("arst_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);

        // sweep against the / % model, with a few forced corners
        for (int i = 0; i < 24; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (i == 3) b = 8'd0;
            if (i == 5) begin sm = 1'b1; a = 8'h80; b = 8'h01; end
            if (i == 7) begin sm = 1'b1; a = 8'h7F; b = 8'h80; end
            if (i == 9) begin sm = 1'b0; a = 8'hFF; b = 8'h01; end
            model(sm, a, b, eq, er, edz, eov);
            run_op(sm, a, b, edges, bok);
            check($sformatf("sw%0d_q", i), 32'(quotient), 32'(eq));
            check($sformatf("sw%0d_r", i), 32'(remainder), 32'(er));
            check($sformatf("sw%0d_fl", i), {30'd0, div_by_zero, overflow}, {30'd0, edz, eov});
            check($sformatf("sw%0d_lat", i), 32'(edges), edz ? 32'd2 : 32'd11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
